// File: rtl/testx_shift_reg_clkgen.sv
// Shared config-clock generator and serial configuration shift register for the
// ip1 test state machines: two free-running phase counters plus a loadable shifter.

module testx_phase_counter #(
  parameter int CW = 7
) (
  input  logic          clk,
  input  logic          clr,
  input  logic [CW-1:0] max_val,
  output logic [CW-1:0] count,
  output logic          phase_clk
);
  localparam logic [CW-1:0] ONE = CW'(1);

  logic [CW-1:0] nxt;

  // A count already past a freshly lowered terminal value rolls on to the
  // natural modulo wrap instead of being clamped.
  always_comb begin
    nxt = (count == max_val) ? '0 : count + ONE;
  end

  always_ff @(posedge clk) begin
    if (clr) begin
      count     <= '0;
      phase_clk <= 1'b0;
    end else begin
      count     <= nxt;
      phase_clk <= (nxt > (max_val >> 1));
    end
  end
endmodule

module testx_shift_reg_clkgen #(
  parameter int WIDTH     = 5188,
  parameter int FC_OFFSET = 24
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             enable,
  input  logic [6:0]       cfg_fc_max,
  input  logic [26:0]      cfg_sc_max,
  input  logic [WIDTH-1:0] load_data,
  input  logic             shift_reg_load,
  input  logic             shift_reg_shift,
  input  logic             capture_in,
  output logic [6:0]       clk_counter_fc,
  output logic [26:0]      clk_counter_sc,
  output logic             fast_config_clk,
  output logic             slow_config_clk,
  output logic             shift_reg_bit0,
  output logic [WIDTH-1:0] shift_reg,
  output logic [12:0]      shift_cnt,
  output logic [12:0]      shift_cnt_max_fc,
  output logic [12:0]      shift_cnt_max_sc
);
  localparam logic [12:0] CNT_SAT = 13'(WIDTH);
  localparam logic [12:0] CNT_FC  = 13'(WIDTH - FC_OFFSET);

  logic clr;
  assign clr = reset | ~enable;

  testx_phase_counter #(.CW(7)) u_fc (
    .clk       (clk),
    .clr       (clr),
    .max_val   (cfg_fc_max),
    .count     (clk_counter_fc),
    .phase_clk (fast_config_clk)
  );

  testx_phase_counter #(.CW(27)) u_sc (
    .clk       (clk),
    .clr       (clr),
    .max_val   (cfg_sc_max),
    .count     (clk_counter_sc),
    .phase_clk (slow_config_clk)
  );

  // Load beats shift; a shift at saturation still moves data but pins the count.
  always_ff @(posedge clk) begin
    if (clr) begin
      shift_reg <= '0;
      shift_cnt <= '0;
    end else if (shift_reg_load) begin
      shift_reg <= load_data;
      shift_cnt <= '0;
    end else if (shift_reg_shift) begin
      shift_reg <= {capture_in, shift_reg[WIDTH-1:1]};
      if (shift_cnt != CNT_SAT) shift_cnt <= shift_cnt + 13'd1;
    end
  end

  assign shift_reg_bit0   = shift_reg[0];
  assign shift_cnt_max_fc = CNT_FC;
  assign shift_cnt_max_sc = CNT_SAT;
endmodule

// File: tb/tb_testx_shift_reg_clkgen.sv
// Randomised and directed checks of testx_shift_reg_clkgen against a simple
// arithmetic/vector reference model (default WIDTH plus a WIDTH=16 instance).

module tb_testx_shift_reg_clkgen;
  localparam int W   = 5188;
  localparam int W16 = 16;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        reset, enable;
  logic [6:0]  cfg_fc_max;
  logic [26:0] cfg_sc_max;

  logic [W-1:0] ld;
  logic         sh_load, sh_shift, loop_en, cap_drv, capture;
  logic [6:0]   fc_cnt;
  logic [26:0]  sc_cnt;
  logic         fclk, sclk, bit0;
  logic [W-1:0] sreg;
  logic [12:0]  scnt, mfc, msc;

  logic [W16-1:0] ld16, sreg16;
  logic           load16, shift16, cap16, bit016, fclk16, sclk16;
  logic [6:0]     fc16;
  logic [26:0]    sc16;
  logic [12:0]    scnt16, mfc16, msc16;

  assign capture = loop_en ? bit0 : cap_drv;

  testx_shift_reg_clkgen dut (
    .clk(clk), .reset(reset), .enable(enable),
    .cfg_fc_max(cfg_fc_max), .cfg_sc_max(cfg_sc_max),
    .load_data(ld), .shift_reg_load(sh_load), .shift_reg_shift(sh_shift),
    .capture_in(capture),
    .clk_counter_fc(fc_cnt), .clk_counter_sc(sc_cnt),
    .fast_config_clk(fclk), .slow_config_clk(sclk),
    .shift_reg_bit0(bit0), .shift_reg(sreg), .shift_cnt(scnt),
    .shift_cnt_max_fc(mfc), .shift_cnt_max_sc(msc)
  );

  testx_shift_reg_clkgen #(.WIDTH(W16), .FC_OFFSET(4)) dut16 (
    .clk(clk), .reset(reset), .enable(enable),
    .cfg_fc_max(cfg_fc_max), .cfg_sc_max(cfg_sc_max),
    .load_data(ld16), .shift_reg_load(load16), .shift_reg_shift(shift16),
    .capture_in(cap16),
    .clk_counter_fc(fc16), .clk_counter_sc(sc16),
    .fast_config_clk(fclk16), .slow_config_clk(sclk16),
    .shift_reg_bit0(bit016), .shift_reg(sreg16), .shift_cnt(scnt16),
    .shift_cnt_max_fc(mfc16), .shift_cnt_max_sc(msc16)
  );

  int total = 0;
  int bad   = 0;

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  logic [W-1:0]   img;
  logic [W16-1:0] m16;
  int             mc, m_fc, t;
  logic           l, s, c;
  logic [15:0]    d;
  logic [15:0]    exp3 [3];

  initial begin
    reset = 1'b1; enable = 1'b1; cfg_fc_max = 7'd9; cfg_sc_max = 27'd99;
    ld = '0; sh_load = 0; sh_shift = 0; loop_en = 0; cap_drv = 0;
    ld16 = '0; load16 = 0; shift16 = 0; cap16 = 0;
    repeat (2) step();

    chk("rst_fc", fc_cnt, 0);
    chk("rst_sc", sc_cnt, 0);
    chk("rst_fclk", fclk, 0);
    chk("rst_sclk", sclk, 0);
    chk("rst_sreg", sreg16, 0);
    chk("rst_scnt", scnt, 0);
    chk("max_fc", mfc, 5164);
    chk("max_sc", msc, 5188);
    chk("max_fc16", mfc16, 12);
    chk("max_sc16", msc16, 16);

    // fast period 10, slow period 100; count after t edges is t mod period
    reset = 0;
    for (int k = 1; k <= 150; k++) begin
      step();
      chk("fc_cnt", fc_cnt, k % 10);
      chk("fc_clk", fclk, (k % 10) > 4);
      chk("sc_cnt", sc_cnt, k % 100);
      chk("sc_clk", sclk, (k % 100) > 49);
    end

    reset = 1; cfg_fc_max = 7'd0; step(); reset = 0;
    repeat (20) begin
      step();
      chk("fc0_cnt", fc_cnt, 0);
      chk("fc0_clk", fclk, 0);
    end

    // lower both terminal values below the current count of 50
    reset = 1; cfg_fc_max = 7'd100; cfg_sc_max = 27'd99; step(); reset = 0;
    repeat (50) step();
    chk("pre_fc", fc_cnt, 50);
    chk("pre_sc", sc_cnt, 50);
    cfg_fc_max = 7'd19; cfg_sc_max = 27'd19;
    m_fc = 50;
    for (int k = 1; k <= 300; k++) begin
      step();
      m_fc = (m_fc == 19) ? 0 : (m_fc + 1) % 128;
      chk("low_fc", fc_cnt, m_fc);
      chk("low_fclk", fclk, m_fc > 9);
      chk("low_sc", sc_cnt, 50 + k);
      chk("low_sclk", sclk, 1);
    end

    // enable low acts as reset
    cfg_fc_max = 7'd9; cfg_sc_max = 27'd99;
    ld16 = 16'h1234; load16 = 1; step(); load16 = 0;
    shift16 = 1; repeat (5) step(); shift16 = 0;
    chk("en_pre_cnt", scnt16, 5);
    enable = 0; step();
    chk("en_fc", fc_cnt, 0);
    chk("en_sc", sc_cnt, 0);
    chk("en_fclk", fclk, 0);
    chk("en_sclk", sclk, 0);
    chk("en_sreg", sreg16, 0);
    chk("en_scnt", scnt16, 0);
    enable = 1; step();
    chk("en_fc1", fc_cnt, 1);
    chk("en_sc1", sc_cnt, 1);

    // directed load and three captured shifts
    ld16 = 16'hA5C3; load16 = 1; step(); load16 = 0;
    chk("ld_sreg", sreg16, 16'hA5C3);
    chk("ld_bit0", bit016, 1);
    chk("ld_cnt", scnt16, 0);
    exp3[0] = 16'hD2E1; exp3[1] = 16'hE970; exp3[2] = 16'hF4B8;
    cap16 = 1;
    for (int i = 0; i < 3; i++) begin
      shift16 = 1; step(); shift16 = 0;
      chk("sh_sreg", sreg16, exp3[i]);
      chk("sh_cnt", scnt16, i + 1);
      step();
      chk("sh_hold", sreg16, exp3[i]);
    end

    // load wins, then saturation
    ld16 = 16'h3C5A; load16 = 1; shift16 = 1; step(); load16 = 0;
    chk("pri_sreg", sreg16, 16'h3C5A);
    chk("pri_cnt", scnt16, 0);
    m16 = 16'h3C5A;
    for (int i = 0; i < 20; i++) begin
      cap16 = 1'($urandom_range(0, 1));
      step();
      m16 = (m16 >> 1) | (W16'(cap16) << 15);
      chk("sat_sreg", sreg16, m16);
      chk("sat_cnt", scnt16, (i + 1 < 16) ? i + 1 : 16);
    end
    shift16 = 0;

    // random load/shift/reset traffic
    m16 = sreg16; mc = 16;
    for (int i = 0; i < 400; i++) begin
      l = ($urandom_range(0, 3) == 0);
      s = 1'($urandom_range(0, 1));
      c = 1'($urandom_range(0, 1));
      d = 16'($urandom);
      t = $urandom_range(0, 39);
      reset = (t == 0); load16 = l; shift16 = s; cap16 = c; ld16 = d;
      step();
      if (t == 0) begin m16 = 0; mc = 0; end
      else if (l) begin m16 = d; mc = 0; end
      else if (s) begin
        m16 = (m16 >> 1) | (W16'(c) << 15);
        mc = (mc < 16) ? mc + 1 : 16;
      end
      chk("rnd_sreg", sreg16, m16);
      chk("rnd_bit0", bit016, m16[0]);
      chk("rnd_cnt", scnt16, mc);
    end
    reset = 0; load16 = 0; shift16 = 0;

    // full-length serial loopback
    for (int i = 0; i < W; i++) img[i] = 1'($urandom_range(0, 1));
    ld = img; sh_load = 1; step(); sh_load = 0;
    chk("lb_load", sreg == img, 1);
    loop_en = 1; sh_shift = 1;
    step();
    chk("lb_bit0_1", bit0, img[1]);
    chk("lb_msb_1", sreg[W-1], img[0]);
    repeat (W - 1) step();
    sh_shift = 0; loop_en = 0;
    chk("lb_img", sreg == img, 1);
    chk("lb_cnt", scnt, 5188);
    chk("lb_max_fc", mfc, 5164);
    chk("lb_max_sc", msc, 5188);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule

// File: doc/testx_shift_reg_clkgen.md
Name: testx_shift_reg_clkgen

Overview:
- Shared upstream stage for the ip1 test state machines (test1..testN).
- Generates the free-running fast and slow config-clock phase counters and the derived config clocks.
- Holds the WIDTH-bit configuration shift register that the test state machines load, shift right and serialise through bit0, and reports the shift count and the per-clock count limits.
- Captures the returning serial stream into the register MSB so a bench or readback can check serial-in/serial-out loopback.

Parameters:
- WIDTH, 5188: shift-register length in bits; must be ≤ 8191.
- FC_OFFSET, 24: bits excluded from fast-clock shifting; shift_cnt_max_fc = WIDTH-FC_OFFSET.

Ports:
- clk  in  1  FM clock, 100 MHz (S_AXI_ACLK).
- reset  in  1  synchronous, active-high.
- enable  in  1  block enable; low behaves as reset.
- cfg_fc_max  in  7  fast phase counter terminal value (period = cfg_fc_max+1 clk).
- cfg_sc_max  in  27  slow phase counter terminal value.
- load_data  in  WIDTH  parallel configuration image.
- shift_reg_load  in  1  load load_data, clear count.
- shift_reg_shift  in  1  shift right one bit.
- capture_in  in  1  serial return bit, inserted at MSB on shift.
- clk_counter_fc  out  7  fast phase counter.
- clk_counter_sc  out  27  slow phase counter.
- fast_config_clk  out  1  derived fast config clock.
- slow_config_clk  out  1  derived slow config clock.
- shift_reg_bit0  out  1  current LSB of the register.
- shift_reg  out  WIDTH  full register, for readback.
- shift_cnt  out  13  shifts since last load.
- shift_cnt_max_fc  out  13  constant WIDTH-FC_OFFSET.
- shift_cnt_max_sc  out  13  constant WIDTH.

Behaviour:
- Everything is registered on posedge clk. Condition R = reset | ~enable.
- Under R: both counters = 0, both config clocks = 0, shift_reg = 0, shift_cnt = 0. The max outputs are constant at all times.
- clk_counter_fc:
  - If equal to cfg_fc_max, next value is 0; otherwise it increments.
  - If cfg_fc_max is lowered below the current count, the counter keeps incrementing and wraps at 127 → 0; no lockup.
- fast_config_clk:
  - Registered; next value = 1 when next counter value > (cfg_fc_max>>1), else 0.
  - This gives exactly one rising edge per period. cfg_fc_max = 0 forces a constant 0.
- clk_counter_sc / slow_config_clk: same rules with cfg_sc_max (27-bit).
- Config inputs are sampled every cycle. A change takes effect at the next wrap comparison; no restart.
- Shift register, in priority order:
  - Load (shift_reg_load=1): shift_reg <= load_data; shift_cnt <= 0. Load wins over a simultaneous shift.
  - Shift (shift_reg_shift=1, load=0): shift_reg <= {capture_in, shift_reg[WIDTH-1:1]}; shift_cnt <= shift_cnt+1, saturating at WIDTH (no wrap to 0).
    - A shift at saturation still shifts data but holds the count at WIDTH.
  - Otherwise: hold.
- Latency:
  - A shift requested in cycle N updates shift_reg_bit0 and shift_cnt visibly in cycle N+1.
  - Consumers asserting shift one cycle before must account for 2 cycles total from their decision. Consumers compare to test_delay-2 for this reason.
- Shift pulses are level-sampled: a request held for k cycles gives k shifts. Consumers must pulse for one clk.
- R mid-operation clears register and count immediately (next edge); no partial state is retained.
- Counters run independently of load/shift activity.

Test Plan:
- Reset/enable: load a pattern, shift 5 times, then drop enable for 1 cycle → next cycle counters=0, clocks=0, shift_reg=0, shift_cnt=0. Re-enable → counters restart from 0.
- Fast clock: cfg_fc_max=9 → clk_counter_fc cycles 0..9. fast_config_clk is low for counts 0..4 and high for 5..9 (period 10, 50% duty). Repeat with cfg_fc_max=0 → counter stuck at 0, clock constant 0.
- Slow clock: cfg_sc_max=99 → period 100 clk, 50 high / 50 low. Change to 19 while the count is 50 → counter runs to 2^27-1 before wrapping. Check the wrap and the first period after it.
- Load/shift: WIDTH=16 override, load 0xA5C3 → bit0=1. Three single-cycle shifts with capture_in=1 → shift_reg=0xF4B8, shift_cnt=3, each update one cycle after its pulse.
- Priority/saturation: load and shift asserted together → register = load_data, cnt=0. Then 20 shifts on WIDTH=16 → shift_cnt saturates at 16 and data keeps shifting.
- Loopback: default WIDTH, load a random image, connect capture_in=shift_reg_bit0, 5188 shifts → register equals the original image and shift_cnt=5188. shift_cnt_max_fc=5164 and shift_cnt_max_sc=5188 throughout.
